// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor: FSM state type, default
// parameter values and a small constant helper for sizing the shared timer.
// -----------------------------------------------------------------------------
package pll_sup_pkg;

   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } pll_sup_state_t;

   localparam int DEF_RST_CYCLES    = 16;
   localparam int DEF_LOCK_TIMEOUT  = 125000;   // 1 ms of 125 MHz refclk
   localparam int DEF_STABLE_CYCLES = 1024;
   localparam int DEF_MAX_RETRIES   = 4;
   localparam int RELOCK_CNT_W      = 8;

   // Largest of three cycle counts; the single timer must cover all of them.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single level signal crossing into clk_i.
// Ports:
//   clk_i  destination clock
//   rst_i  asynchronous active-high reset, clears both stages to 0
//   d_i    asynchronous input level
//   q_o    synchronized level, two clk_i edges after capture
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         // NOTE: non-blocking keeps this a true two-stage chain; blocking
         // assignments here would collapse both flops into one.
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences the board PLL from its reference clock: pulses the PLL reset,
// waits for lock, qualifies lock for stability, then releases the system
// reset. Lock loss or a forced request re-runs the sequence; repeated lock
// timeouts latch a fault until force_relock is asserted.
// Ports:
//   refclk        reference clock (also feeds the PLL)
//   rst           asynchronous active-high reset
//   pll_locked    PLL lock indication, asynchronous to refclk
//   force_relock  single-cycle re-lock request (honoured in RUN and FAULT)
//   pll_rst       PLL reset output
//   sys_rst       reset for the PLL output clock domains
//   lock_ok       high only in RUN
//   fault         high only in FAULT
//   relock_cnt    number of RUN->RESET_PLL transitions, saturating at 255
// -----------------------------------------------------------------------------
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
   input  logic                    refclk,
   input  logic                    rst,
   input  logic                    pll_locked,
   input  logic                    force_relock,
   output logic                    pll_rst,
   output logic                    sys_rst,
   output logic                    lock_ok,
   output logic                    fault,
   output logic [RELOCK_CNT_W-1:0] relock_cnt
);

   // One timer serves RESET_PLL, WAIT_LOCK and STABLE, so it is sized for
   // the longest of the three intervals.
   localparam int TMR_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

   localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRIES);
   localparam logic [RELOCK_CNT_W-1:0] RELOCK_SAT = '1;

   logic locked_s;

   pll_sup_state_t          state_q,  state_d;
   logic [TMR_W-1:0]        timer_q,  timer_d;
   logic [RTY_W-1:0]        retry_q,  retry_d;
   logic [RTY_W-1:0]        retry_inc;
   logic [RELOCK_CNT_W-1:0] relock_q, relock_d;
   logic pll_rst_q, pll_rst_d;
   logic sys_rst_q, sys_rst_d;
   logic lock_ok_q, lock_ok_d;
   logic fault_q,   fault_d;

   sync_2ff u_lock_sync (
      .clk_i (refclk),
      .rst_i (rst),
      .d_i   (pll_locked),
      .q_o   (locked_s)
   );

   // Next-state logic: FSM, shared timer, retry and relock counters.
   always_comb begin
      // NOTE: every next-state signal gets a default before the case so no
      // branch leaves one unassigned, which would infer a latch.
      state_d   = state_q;
      timer_d   = timer_q;
      retry_d   = retry_q;
      relock_d  = relock_q;
      retry_inc = retry_q + RTY_W'(1);

      unique case (state_q)
         ST_RESET_PLL: begin
            if (timer_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         ST_WAIT_LOCK: begin
            // A lock seen on the last timeout cycle still wins.
            if (locked_s) begin
               state_d = ST_STABLE;
               timer_d = '0;
            end else if (timer_q == LOCK_LAST) begin
               timer_d = '0;
               retry_d = retry_inc;
               state_d = (retry_inc == RTY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         ST_STABLE: begin
            // A dropout restarts qualification without spending a retry.
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               timer_d = '0;
            end else if (timer_q == STABLE_LAST) begin
               state_d = ST_RUN;
               timer_d = '0;
               retry_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         ST_RUN: begin
            // Lock loss and a forced request in the same cycle are one event.
            if (!locked_s || force_relock) begin
               state_d = ST_RESET_PLL;
               timer_d = '0;
               if (relock_q != RELOCK_SAT) relock_d = relock_q + RELOCK_CNT_W'(1);
            end
         end

         ST_FAULT: begin
            if (force_relock) begin
               state_d = ST_RESET_PLL;
               timer_d = '0;
               retry_d = '0;
            end
         end

         default: begin
            state_d = ST_RESET_PLL;
            timer_d = '0;
         end
      endcase

      // Outputs decode the next state so they switch on the same edge.
      pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
      sys_rst_d = (state_d != ST_RUN);
      lock_ok_d = (state_d == ST_RUN);
      fault_d   = (state_d == ST_FAULT);
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RESET_PLL;
         timer_q   <= '0;
         retry_q   <= '0;
         relock_q  <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         lock_ok_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         retry_q   <= retry_d;
         relock_q  <= relock_d;
         pll_rst_q <= pll_rst_d;
         sys_rst_q <= sys_rst_d;
         lock_ok_q <= lock_ok_d;
         fault_q   <= fault_d;
      end
   end

   assign pll_rst    = pll_rst_q;
   assign sys_rst    = sys_rst_q;
   assign lock_ok    = lock_ok_q;
   assign fault      = fault_q;
   assign relock_cnt = relock_q;

endmodule
